ones_cnt_pipe: RTL and testbench
================================

// Module: ones_cnt_pipe
// PURPOSE
//  Pipelined, parametrised population counter with valid/ready flow control and per-packet accumulation.
//  Successor to the combinational ones counter. The count is LOG_VEC_SIZE+1 bits wide, so an all-ones vector is representable.
//  Sits between the prefetcher's access-history bitmap producer and the stride/density scoring logic.
// PARAMETERS
//  LOG_VEC_SIZE  3   log2 of input vector width; legal range 1..6; VEC_SIZE = 1<<LOG_VEC_SIZE
//  ACC_W         16  width of the per-packet running total; must be >= LOG_VEC_SIZE+1
// PORTS
//  clk            in   1               single clock, rising edge
//  rst            in   1               synchronous, active-high reset
//  in_valid       in   1               input beat present
//  in_ready       out  1               block accepts a beat this cycle
//  in_vec         in   [0:VEC_SIZE-1]  vector to count; index 0 is leftmost
//  in_last        in   1               beat closes the current packet
//  out_valid      out  1               result present
//  out_ready      in   1               consumer takes the result
//  out_ones       out  LOG_VEC_SIZE+1  set-bit count of this beat, 0..VEC_SIZE
//  out_acc        out  ACC_W           packet running total, including this beat
//  out_acc_ovf    out  1               sticky: packet total saturated
//  out_last       out  1               in_last of this beat, delayed
//  out_first_idx  out  LOG_VEC_SIZE    [ONES_CNT_FIRST_IDX_EN only] index of lowest set bit, 0 if none
// BEHAVIOUR
//  - Reset: out_valid=0, out_ones=0, out_acc=0, out_acc_ovf=0, out_last=0, and out_first_idx=0 if compiled in.
//    All stage valids clear; accumulator FSM goes to IDLE. Asserting rst mid-operation drops in-flight beats silently.
//  - Pipeline:
//    - LOG_VEC_SIZE register stages, one per adder-tree level. Level k adds pairs of (k+1)-bit partial sums.
//    - Latency: a beat accepted at edge N is on the outputs after edge N+LOG_VEC_SIZE, provided there is no stall.
//    - Throughput: 1 beat per cycle.
//  - Flow control:
//    - adv = out_ready | ~out_valid. When adv=1, all stages shift together. When adv=0, all stages hold and outputs stay stable.
//    - in_ready = adv (combinational from out_ready). A beat is accepted when in_valid & in_ready.
//    - Empty stages carry valid=0, so bubbles propagate.
//    - out_valid never drops without an out_ready handshake.
//  - Accumulator FSM, updated in the final stage when a valid beat is loaded:
//    - IDLE: acc = ones, ovf = 0. Go to OPEN if last=0; stay in IDLE if last=1.
//    - OPEN: acc = acc_prev + ones, saturating at 2^ACC_W-1. ovf |= carry-out. Go to IDLE if last=1.
//    - out_acc / out_acc_ovf are the values registered alongside the beat. A last beat therefore shows the packet total.
//  - Boundaries:
//    - all-zero vector -> 0; all-ones vector -> VEC_SIZE.
//    - Saturation holds until the next last beat; the following packet starts clean.
//    - in_valid with in_ready=0 is not accepted; the source must hold its data.
// CONFIGURATION
//  - Macro ONES_CNT_FIRST_IDX_EN:
//    - Defined: out_first_idx is present. A priority encoder is pipelined in parallel with the adder tree, with the same latency and stall behaviour.
//    - Undefined: the port and its logic are absent; everything else is identical.
// STRUCTURE
//  - Package ones_cnt_pkg:
//    - localparam helper functions vec_size(log) and cnt_w(log)
//    - typedef enum logic {ACC_IDLE, ACC_OPEN} acc_state_e
//  - Sub-module ones_cnt_level: one tree level.
//    - Parameters: IN_W, N_IN.
//    - Adds adjacent pairs and registers the result with valid/last/enable.
//    - Instantiated LOG_VEC_SIZE times in a generate loop.
// TESTING
//  - LOG_VEC_SIZE=3, out_ready=1, single beats:
//    - 8'b0000_0000 -> 0; 8'b0100_0000 -> 1; 8'b1001_1100 -> 4; 8'b1111_1111 -> 8.
//    - Each appears exactly 3 cycles after acceptance.
//  - Back-to-back stream of 4 beats {8'hFF, 8'h01, 8'h80, 8'h00} with in_last on beat 4:
//    - out_ones 8,1,1,0 and out_acc 8,9,10,10 on consecutive cycles; out_last only on beat 4.
//  - Stall: drop out_ready for 5 cycles while results are pending:
//    - in_ready=0 during the stall; outputs stay frozen; no beat is lost or duplicated; order is preserved.
//  - ACC_W=4, packet of three 8'hFF beats:
//    - out_acc 8,15,15 and out_acc_ovf 0,1,1.
//    - Next packet with 8'h03 as a last beat -> out_acc=2, out_acc_ovf=0.
//  - Assert rst for 1 cycle with 2 beats in flight:
//    - The next cycle has out_valid=0 and out_acc=0.
//    - The next packet accumulates from 0.
//  - With ONES_CNT_FIRST_IDX_EN, LOG_VEC_SIZE=3:
//    - 8'b0010_1000 -> out_first_idx=2; 8'b0000_0001 -> 7; 8'h00 -> 0 with out_ones=0.

Source files
------------

// File: rtl/ones_cnt_pkg.sv
// Shared sizing helpers and accumulator state encoding for the pipelined ones counter.
package ones_cnt_pkg;

  function automatic int vec_size(input int lg);
    return 1 << lg;
  endfunction

  function automatic int cnt_w(input int lg);
    return lg + 1;
  endfunction

  typedef enum logic {ACC_IDLE, ACC_OPEN} acc_state_e;

endpackage

// File: rtl/ones_cnt_level.sv
// One adder-tree level: sums adjacent pairs of IN_W-bit partial counts into IN_W+1 bits, registered.
// With ONES_CNT_FIRST_IDX_EN defined it also merges pairs of (any, lowest-index) nodes.
module ones_cnt_level
  import ones_cnt_pkg::*;
#(
  parameter int IN_W = 1,
  parameter int N_IN = 8,
  localparam int N_OUT = N_IN / 2,
  localparam int OUT_W = IN_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   in_sum,
`ifdef ONES_CNT_FIRST_IDX_EN
  input  logic [N_IN-1:0]        in_any,
  input  logic [N_IN*IN_W-1:0]   in_idx,
  output logic [N_OUT-1:0]       out_any,
  output logic [N_OUT*OUT_W-1:0] out_idx,
`endif
  output logic                   out_valid,
  output logic                   out_last,
  output logic [N_OUT*OUT_W-1:0] out_sum
);

  logic [N_OUT*OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      sum_d[j*OUT_W +: OUT_W] = OUT_W'(in_sum[2*j*IN_W +: IN_W])
                              + OUT_W'(in_sum[(2*j+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      out_sum   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_sum   <= sum_d;
    end
  end

`ifdef ONES_CNT_FIRST_IDX_EN
  // Right child's index gains the new top bit; a node with no set bit reports 0.
  localparam logic [OUT_W-1:0] HI = OUT_W'(1) << (IN_W - 1);

  logic [N_OUT-1:0]       any_d;
  logic [N_OUT*OUT_W-1:0] idx_d;

  always_comb begin
    any_d = '0;
    idx_d = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      any_d[j] = in_any[2*j] | in_any[2*j+1];
      if (in_any[2*j])
        idx_d[j*OUT_W +: OUT_W] = OUT_W'(in_idx[2*j*IN_W +: IN_W]);
      else if (in_any[2*j+1])
        idx_d[j*OUT_W +: OUT_W] = OUT_W'(in_idx[(2*j+1)*IN_W +: IN_W]) | HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_any <= '0;
      out_idx <= '0;
    end else if (en) begin
      out_any <= any_d;
      out_idx <= idx_d;
    end
  end
`endif

endmodule

// File: rtl/ones_cnt_pipe.sv
// Pipelined population counter with valid/ready flow control and per-packet saturating accumulation.
// Optional lowest-set-index output enabled by defining ONES_CNT_FIRST_IDX_EN.
module ones_cnt_pipe
  import ones_cnt_pkg::*;
#(
  parameter int LOG_VEC_SIZE = 3,
  parameter int ACC_W        = 16,
  localparam int VEC_SIZE    = vec_size(LOG_VEC_SIZE),
  localparam int CNT_W       = cnt_w(LOG_VEC_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:VEC_SIZE-1]     in_vec,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_ones,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_acc_ovf,
  output logic                    out_last
`ifdef ONES_CNT_FIRST_IDX_EN
  ,
  output logic [LOG_VEC_SIZE-1:0] out_first_idx
`endif
);

  logic                adv;
  logic [VEC_SIZE-1:0] vec_flat;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    vec_flat = '0;
    for (int unsigned i = 0; i < VEC_SIZE; i++) vec_flat[i] = in_vec[i];
  end

  for (genvar k = 0; k < LOG_VEC_SIZE; k++) begin : g_lvl
    localparam int IN_W  = k + 1;
    localparam int N_IN  = VEC_SIZE >> k;
    localparam int N_OUT = N_IN / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_IN*IN_W-1:0]   op;
    logic                   op_valid;
    logic                   op_last;
    logic [N_OUT*OUT_W-1:0] sum;
    logic                   valid;
    logic                   last;
`ifdef ONES_CNT_FIRST_IDX_EN
    logic [N_IN-1:0]        op_any;
    logic [N_IN*IN_W-1:0]   op_idx;
    logic [N_OUT-1:0]       any;
    logic [N_OUT*OUT_W-1:0] idx;
`endif

    if (k == 0) begin : g_head
      assign op       = vec_flat;
      assign op_valid = in_valid;
      assign op_last  = in_last;
`ifdef ONES_CNT_FIRST_IDX_EN
      assign op_any   = vec_flat;
      assign op_idx   = '0;
`endif
    end else begin : g_tail
      assign op       = g_lvl[k-1].sum;
      assign op_valid = g_lvl[k-1].valid;
      assign op_last  = g_lvl[k-1].last;
`ifdef ONES_CNT_FIRST_IDX_EN
      assign op_any   = g_lvl[k-1].any;
      assign op_idx   = g_lvl[k-1].idx;
`endif
    end

    ones_cnt_level #(
      .IN_W (IN_W),
      .N_IN (N_IN)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (op_valid),
      .in_last   (op_last),
      .in_sum    (op),
`ifdef ONES_CNT_FIRST_IDX_EN
      .in_any    (op_any),
      .in_idx    (op_idx),
      .out_any   (any),
      .out_idx   (idx),
`endif
      .out_valid (valid),
      .out_last  (last),
      .out_sum   (sum)
    );
  end

  assign out_valid = g_lvl[LOG_VEC_SIZE-1].valid;
  assign out_last  = g_lvl[LOG_VEC_SIZE-1].last;
  assign out_ones  = g_lvl[LOG_VEC_SIZE-1].sum;

`ifdef ONES_CNT_FIRST_IDX_EN
  logic unused_idx;
  assign out_first_idx = g_lvl[LOG_VEC_SIZE-1].idx[LOG_VEC_SIZE-1:0];
  assign unused_idx    = &{1'b0, g_lvl[LOG_VEC_SIZE-1].any, g_lvl[LOG_VEC_SIZE-1].idx[LOG_VEC_SIZE]};
`endif

  // The accumulator loads on the same edge as the final level, so it recomputes
  // that level's pair sum from the final level's operands.
  logic [CNT_W-1:0] fin_ones;
  logic             fin_valid;
  logic             fin_last;

  assign fin_ones  = CNT_W'(g_lvl[LOG_VEC_SIZE-1].op[LOG_VEC_SIZE-1:0])
                   + CNT_W'(g_lvl[LOG_VEC_SIZE-1].op[2*LOG_VEC_SIZE-1:LOG_VEC_SIZE]);
  assign fin_valid = g_lvl[LOG_VEC_SIZE-1].op_valid;
  assign fin_last  = g_lvl[LOG_VEC_SIZE-1].op_last;

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(fin_ones);
    if (adv && fin_valid) begin
      unique case (state_q)
        ACC_IDLE: begin
          acc_d = ACC_W'(fin_ones);
          ovf_d = 1'b0;
        end
        ACC_OPEN: begin
          if (acc_sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum[ACC_W-1:0];
          end
        end
        default: ;
      endcase
      state_d = fin_last ? ACC_IDLE : ACC_OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_acc     = acc_q;
  assign out_acc_ovf = ovf_q;

endmodule

// File: tb/tb_ones_cnt_pipe.sv
// Directed self-checking bench for ones_cnt_pipe (default ACC_W instance plus an ACC_W=4 instance).
module tb_ones_cnt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_acc_ovf, out_last;
  logic [0:7]  in_vec;
  logic [3:0]  out_ones;
  logic [15:0] out_acc;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_acc_ovf, b_out_last;
  logic [0:7]  b_in_vec;
  logic [3:0]  b_out_ones;
  logic [3:0]  b_out_acc;

`ifdef ONES_CNT_FIRST_IDX_EN
  logic [2:0]  out_first_idx, b_out_first_idx;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ones_cnt_pipe #(.LOG_VEC_SIZE(3), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_ones(out_ones),
    .out_acc(out_acc), .out_acc_ovf(out_acc_ovf), .out_last(out_last)
`ifdef ONES_CNT_FIRST_IDX_EN
    , .out_first_idx(out_first_idx)
`endif
  );

  ones_cnt_pipe #(.LOG_VEC_SIZE(3), .ACC_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ones(b_out_ones),
    .out_acc(b_out_acc), .out_acc_ovf(b_out_acc_ovf), .out_last(b_out_last)
`ifdef ONES_CNT_FIRST_IDX_EN
    , .out_first_idx(b_out_first_idx)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_ones !== 4'd0) begin n_fail++; $display("FAIL reset_out_ones: got %0d want 0", out_ones); end
    n_tests++; if (out_acc !== 16'd0) begin n_fail++; $display("FAIL reset_out_acc: got %0d want 0", out_acc); end
    n_tests++; if (out_acc_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_acc_ovf: got %b want 0", out_acc_ovf); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (b_out_valid !== 1'b0 || b_out_acc !== 4'd0) begin n_fail++; $display("FAIL reset_acc4: got valid=%b acc=%0d want 0/0", b_out_valid, b_out_acc); end
`ifdef ONES_CNT_FIRST_IDX_EN
    n_tests++; if (out_first_idx !== 3'd0) begin n_fail++; $display("FAIL reset_first_idx: got %0d want 0", out_first_idx); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_beats;
    logic [0:7] vecs [4];
    logic [3:0] exp  [4];
    vecs = '{8'b0000_0000, 8'b0100_0000, 8'b1001_1100, 8'b1111_1111};
    exp  = '{4'd0, 4'd1, 4'd4, 4'd8};
    for (int i = 0; i < 4; i++) begin
      in_vec = vecs[i]; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single%0d_early1: out_valid got %b want 0", i, out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single%0d_early2: out_valid got %b want 0", i, out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single%0d_valid: got %b want 1", i, out_valid); end
      n_tests++; if (out_ones !== exp[i]) begin n_fail++; $display("FAIL single%0d_ones: got %0d want %0d", i, out_ones, exp[i]); end
      n_tests++; if (out_acc !== 16'(exp[i])) begin n_fail++; $display("FAIL single%0d_acc: got %0d want %0d", i, out_acc, exp[i]); end
      n_tests++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single%0d_last: got %b want 1", i, out_last); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [0:7]  vecs  [4];
    logic [3:0]  eones [4];
    logic [15:0] eacc  [4];
    vecs  = '{8'hFF, 8'h01, 8'h80, 8'h00};
    eones = '{4'd8, 4'd1, 4'd1, 4'd0};
    eacc  = '{16'd8, 16'd9, 16'd10, 16'd10};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_vec = vecs[c]; in_last = (c == 3);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
      if (c >= 2) begin
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid: got %b want 1", c-2, out_valid); end
        n_tests++; if (out_ones !== eones[c-2]) begin n_fail++; $display("FAIL b2b%0d_ones: got %0d want %0d", c-2, out_ones, eones[c-2]); end
        n_tests++; if (out_acc !== eacc[c-2]) begin n_fail++; $display("FAIL b2b%0d_acc: got %0d want %0d", c-2, out_acc, eacc[c-2]); end
        n_tests++; if (out_last !== (c == 5)) begin n_fail++; $display("FAIL b2b%0d_last: got %b want %b", c-2, out_last, (c == 5)); end
      end
    end
    tick();
  endtask

  task automatic test_stall;
    logic [0:7]  vecs  [4];
    logic [3:0]  eones [4];
    logic [15:0] eacc  [4];
    logic [3:0]  snap_ones;
    logic [15:0] snap_acc;
    int src = 0;
    int got = 0;
    vecs  = '{8'h01, 8'h03, 8'h07, 8'h0F};
    eones = '{4'd1, 4'd2, 4'd3, 4'd4};
    eacc  = '{16'd1, 16'd3, 16'd6, 16'd10};
    snap_ones = '0; snap_acc = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid  = (src < 4);
      in_vec    = vecs[(src < 4) ? src : 0];
      in_last   = (src == 3);
      out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (cyc == 3) begin snap_ones = out_ones; snap_acc = out_acc; end
      if (cyc >= 3 && cyc < 8) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b want 0", cyc, in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid c%0d: got %b want 1", cyc, out_valid); end
        if (cyc > 3) begin
          n_tests++; if (out_ones !== snap_ones || out_acc !== snap_acc) begin n_fail++; $display("FAIL stall_frozen c%0d: got ones=%0d acc=%0d want %0d/%0d", cyc, out_ones, out_acc, snap_ones, snap_acc); end
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_tests++; if (out_ones !== eones[got] || out_acc !== eacc[got] || out_last !== (got == 3)) begin
          n_fail++; $display("FAIL stall_beat%0d: got ones=%0d acc=%0d last=%b want %0d/%0d/%b", got, out_ones, out_acc, out_last, eones[got], eacc[got], (got == 3));
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) src++;
      tick();
    end
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL stall_timeout: got %0d beats want 4", got); end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup c%0d: out_valid got %b want 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_acc_saturate;
    logic [0:7] vecs  [4];
    logic       lasts [4];
    logic [3:0] eacc  [4];
    logic       eovf  [4];
    vecs  = '{8'hFF, 8'hFF, 8'hFF, 8'h03};
    lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
    eacc  = '{4'd8, 4'd15, 4'd15, 4'd2};
    eovf  = '{1'b0, 1'b1, 1'b1, 1'b0};
    b_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        b_in_valid = 1'b1; b_in_vec = vecs[c]; b_in_last = lasts[c];
      end else begin
        b_in_valid = 1'b0; b_in_last = 1'b0;
      end
      tick();
      if (c >= 2) begin
        n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL sat%0d_valid: got %b want 1", c-2, b_out_valid); end
        n_tests++; if (b_out_acc !== eacc[c-2]) begin n_fail++; $display("FAIL sat%0d_acc: got %0d want %0d", c-2, b_out_acc, eacc[c-2]); end
        n_tests++; if (b_out_acc_ovf !== eovf[c-2]) begin n_fail++; $display("FAIL sat%0d_ovf: got %b want %b", c-2, b_out_acc_ovf, eovf[c-2]); end
      end
    end
    tick();
  endtask

  task automatic test_reset_in_flight;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_vec = 8'hFF; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_acc !== 16'd8) begin n_fail++; $display("FAIL rstfl_pre: got valid=%b acc=%0d want 1/8", out_valid, out_acc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_valid: got %b want 0", out_valid); end
    n_tests++; if (out_acc !== 16'd0 || out_acc_ovf !== 1'b0) begin n_fail++; $display("FAIL rstfl_acc: got acc=%0d ovf=%b want 0/0", out_acc, out_acc_ovf); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_dropped c%0d: out_valid got %b want 0", c, out_valid); end
    end
    in_valid = 1'b1; in_vec = 8'h07; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_ones !== 4'd3 || out_acc !== 16'd3) begin
      n_fail++; $display("FAIL rstfl_next: got valid=%b ones=%0d acc=%0d want 1/3/3", out_valid, out_ones, out_acc);
    end
    tick();
  endtask

`ifdef ONES_CNT_FIRST_IDX_EN
  task automatic test_first_idx;
    logic [0:7] vecs  [3];
    logic [2:0] eidx  [3];
    logic [3:0] eones [3];
    vecs  = '{8'b0010_1000, 8'b0000_0001, 8'h00};
    eidx  = '{3'd2, 3'd7, 3'd0};
    eones = '{4'd2, 4'd1, 4'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_vec = vecs[i]; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_first_idx !== eidx[i] || out_ones !== eones[i]) begin
        n_fail++; $display("FAIL first_idx%0d: got valid=%b idx=%0d ones=%0d want 1/%0d/%0d", i, out_valid, out_first_idx, out_ones, eidx[i], eones[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_vec = '0; in_last = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_vec = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_single_beats();
    test_back_to_back();
    test_stall();
    test_acc_saturate();
    test_reset_in_flight();
`ifdef ONES_CNT_FIRST_IDX_EN
    test_first_idx();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
